// File: rtl/eco_patch_lut_array_if.sv
// eco_patch_lut_array_if: config, evaluation and sweep signals of the patch LUT array
interface eco_patch_lut_array_if #(
  parameter int NIN = 3,
  parameter int CH = 4,
  parameter int SIG_W = 16
);
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  logic cfg_valid;
  logic cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [(1<<NIN)-1:0] cfg_lut;
  logic in_valid;
  logic [CH*NIN-1:0] in_data;
  logic out_valid;
  logic [CH-1:0] out_data;
  logic sweep_start;
  logic [CW-1:0] sweep_ch;
  logic sweep_busy;
  logic sweep_done;
  logic [SIG_W-1:0] sweep_sig;
  modport master (
    output cfg_valid, cfg_ch, cfg_lut, in_valid, in_data, sweep_start, sweep_ch,
    input cfg_ready, out_valid, out_data, sweep_busy, sweep_done, sweep_sig
  );
  modport slave (
    input cfg_valid, cfg_ch, cfg_lut, in_valid, in_data, sweep_start, sweep_ch,
    output cfg_ready, out_valid, out_data, sweep_busy, sweep_done, sweep_sig
  );
endinterface

// File: rtl/eco_patch_lut_array.sv
// eco_patch_lut_array: CH programmable NIN-input LUT patches with registered evaluation
// and a sweep engine that folds one channel's truth table into a rotate-xor signature.
module eco_patch_lut_array #(
  parameter int NIN = 3,
  parameter int CH = 4,
  parameter int SIG_W = 16
) (
  input logic clk,
  input logic rst_n,
  eco_patch_lut_array_if.slave bus
);
  localparam int L = 1 << NIN;
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;
  state_t r_state, w_next;
  logic [L-1:0] r_lut [CH];
  logic [CW-1:0] r_ch;
  logic [NIN:0] r_cnt;
  logic [SIG_W-1:0] r_sig;
  logic [CH-1:0] r_od;
  logic r_ov;
  logic w_cfg_we, w_start, w_last, w_bit;
  assign w_cfg_we = bus.cfg_valid && r_state == S_IDLE && 32'(bus.cfg_ch) < CH;
  assign w_start = bus.sweep_start && r_state == S_IDLE;
  assign w_last = r_cnt == (NIN+1)'(L-1);
  assign w_bit = r_lut[r_ch][r_cnt[NIN-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == S_IDLE  ? (bus.sweep_start ? S_SWEEP : S_IDLE) :
             r_state == S_SWEEP ? (w_last ? S_DONE : S_SWEEP) : S_IDLE;
  always_comb begin
    bus.cfg_ready = r_state == S_IDLE;
    bus.sweep_busy = r_state == S_SWEEP;
    bus.sweep_done = r_state == S_DONE;
  end
  // evaluation reads r_lut before any same-edge write lands
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) r_lut[i] <= '0;
      r_ch <= '0;
      r_cnt <= '0;
      r_sig <= '0;
      r_od <= '0;
      r_ov <= 1'b0;
    end else begin
      r_ov <= bus.in_valid;
      if (bus.in_valid)
        for (int c = 0; c < CH; c++) r_od[c] <= r_lut[c][bus.in_data[c*NIN +: NIN]];
      if (w_cfg_we) r_lut[bus.cfg_ch] <= bus.cfg_lut;
      if (w_start) begin
        r_ch <= 32'(bus.sweep_ch) < CH ? bus.sweep_ch : '0;
        r_cnt <= '0;
        r_sig <= '0;
      end else if (r_state == S_SWEEP) begin
        r_sig <= {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ SIG_W'(w_bit);
        r_cnt <= r_cnt + 1'b1;
      end
    end
  assign bus.out_valid = r_ov;
  assign bus.out_data = r_od;
  assign bus.sweep_sig = r_sig;
endmodule

// File: tb/tb_eco_patch_lut_array.sv
// tb_eco_patch_lut_array: random and directed stimulus against a behavioural model
module tb_eco_patch_lut_array;
  localparam int NIN = 3, CH = 4, SIG_W = 16, L = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [L-1:0] m_lut [CH];
  logic m_ov, m_done;
  logic [CH-1:0] m_od;
  logic [SIG_W-1:0] m_sig, m_pend;
  int m_busy;
  eco_patch_lut_array_if #(.NIN(NIN), .CH(CH), .SIG_W(SIG_W)) bus ();
  eco_patch_lut_array #(.NIN(NIN), .CH(CH), .SIG_W(SIG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [SIG_W-1:0] sig_of(input logic [L-1:0] t);
    logic [SIG_W-1:0] s = '0;
    for (int k = 0; k < L; k++) s = {s[SIG_W-2:0], s[SIG_W-1]} ^ SIG_W'(t[k]);
    return s;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < CH; i++) m_lut[i] = '0;
    m_ov = 0; m_od = '0; m_sig = '0; m_pend = '0; m_busy = 0; m_done = 0;
  endtask
  task automatic check_all();
    logic idle;
    idle = m_busy == 0 && !m_done;
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("out_data", 32'(bus.out_data), 32'(m_od));
    check("cfg_ready", 32'(bus.cfg_ready), 32'(idle));
    check("sweep_busy", 32'(bus.sweep_busy), 32'(m_busy > 0));
    check("sweep_done", 32'(bus.sweep_done), 32'(m_done));
    if (m_busy == 0) check("sweep_sig", 32'(bus.sweep_sig), 32'(m_sig));
  endtask
  task automatic tick();
    logic idle;
    idle = m_busy == 0 && !m_done;
    if (bus.in_valid)
      for (int c = 0; c < CH; c++) m_od[c] = m_lut[c][bus.in_data[c*NIN +: NIN]];
    m_ov = bus.in_valid;
    if (idle && bus.cfg_valid) m_lut[bus.cfg_ch] = bus.cfg_lut;
    if (m_done) m_done = 0;
    else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_done = 1; m_sig = m_pend; end
    end else if (bus.sweep_start) begin
      m_busy = L; m_sig = '0; m_pend = sig_of(m_lut[bus.sweep_ch]);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic tick_chk();
    tick();
    check_all();
  endtask
  task automatic quiet();
    bus.cfg_valid = 0; bus.cfg_ch = '0; bus.cfg_lut = '0; bus.in_valid = 0;
    bus.in_data = '0; bus.sweep_start = 0; bus.sweep_ch = '0;
  endtask
  task automatic noise();
    bus.cfg_valid = 1'($urandom); bus.cfg_ch = 2'($urandom); bus.cfg_lut = 8'($urandom);
    bus.in_valid = 1'($urandom); bus.in_data = 12'($urandom);
    bus.sweep_start = 1'($urandom); bus.sweep_ch = 2'($urandom);
  endtask
  task automatic run_sweep(input logic [SIG_W-1:0] exp_sig, input bit busy_noise);
    int nb = 0;
    bit seen = 0;
    for (int i = 0; i < 24 && !seen; i++) begin
      if (bus.sweep_busy) nb++;
      if (bus.sweep_done) seen = 1;
      else begin
        if (busy_noise) noise(); else quiet();
        tick_chk();
      end
    end
    check("sweep_done_seen", 32'(seen), 32'd1);
    check("busy_cycles", nb, 32'd8);
    check("sweep_sig_exp", 32'(bus.sweep_sig), 32'(exp_sig));
    quiet();
    tick_chk();
  endtask
  initial begin
    quiet();
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    #1;
    check_all();
    bus.in_valid = 1; bus.in_data = 12'($urandom);
    tick_chk();
    check("reset_eval", 32'(bus.out_data), 32'h0);
    // majority on ch0
    quiet(); bus.cfg_valid = 1; bus.cfg_ch = 0; bus.cfg_lut = 8'hE8;
    tick_chk();
    quiet(); bus.in_valid = 1; bus.in_data = 12'h003;
    tick_chk();
    check("maj_011", 32'(bus.out_data[0]), 32'd1);
    bus.in_data = 12'h004;
    tick_chk();
    check("maj_100", 32'(bus.out_data[0]), 32'd0);
    check("maj_valid", 32'(bus.out_valid), 32'd1);
    quiet();
    tick_chk();
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("data_hold", 32'(bus.out_data[0]), 32'd0);
    // sweep ch2 with config/start/eval noise while busy
    bus.cfg_valid = 1; bus.cfg_ch = 2; bus.cfg_lut = 8'hE8;
    tick_chk();
    quiet(); bus.sweep_start = 1; bus.sweep_ch = 2;
    tick_chk();
    run_sweep(16'h0017, 1'b1);
    // simultaneous write and sweep start
    bus.cfg_valid = 1; bus.cfg_ch = 1; bus.cfg_lut = 8'hFF; bus.sweep_start = 1; bus.sweep_ch = 1;
    tick_chk();
    run_sweep(16'h00FF, 1'b0);
    for (int i = 0; i < 400; i++) begin
      bus.cfg_valid = ($urandom % 3) == 0; bus.cfg_ch = 2'($urandom); bus.cfg_lut = 8'($urandom);
      bus.in_valid = 1'($urandom); bus.in_data = 12'($urandom);
      bus.sweep_start = ($urandom % 12) == 0; bus.sweep_ch = 2'($urandom);
      tick_chk();
    end
    quiet();
    repeat (12) tick_chk();
    // reset mid-sweep
    bus.cfg_valid = 1; bus.cfg_ch = 0; bus.cfg_lut = 8'hA5;
    tick_chk();
    quiet(); bus.sweep_start = 1; bus.sweep_ch = 0;
    tick_chk();
    quiet();
    repeat (3) tick_chk();
    rst_n = 0;
    #1;
    m_reset();
    check("rst_busy", 32'(bus.sweep_busy), 32'd0);
    check("rst_sig", 32'(bus.sweep_sig), 32'd0);
    check_all();
    @(posedge clk); #1;
    check_all();
    rst_n = 1;
    for (int k = 0; k < L; k++) begin
      bus.in_valid = 1; bus.in_data = 12'(k);
      tick_chk();
      check("rst_lut0", 32'(bus.out_data[0]), 32'd0);
    end
    quiet();
    tick_chk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/eco_patch_lut_array.md
Name: eco_patch_lut_array

Overview:
- Parametrised successor to the team's fixed single-output ECO patch netlists.
- Provides CH independent NIN-input programmable patch functions, each held as a 2^NIN-bit truth table (LUT) and loaded through a valid/ready config port.
- Evaluates all channels in parallel with a registered output.
- Includes a self-check sweep engine that walks every input pattern of one channel and produces a signature, so a loaded patch can be compared against the golden function without external stimulus.

Parameters:
- NIN, 3: inputs per patch function; LUT depth is 2^NIN.
- CH, 4: number of independent patch channels.
- SIG_W, 16: sweep signature width. Must satisfy SIG_W >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config word offered.
- cfg_ready  out  1  config word can be accepted.
- cfg_ch  in  clog2(CH)  target channel for the config word.
- cfg_lut  in  2^NIN  truth table; bit k is the output for input index k.
- in_valid  in  1  evaluation input qualifier.
- in_data  in  CH*NIN  channel c input index = in_data[c*NIN +: NIN], unsigned.
- out_valid  out  1  evaluation result valid.
- out_data  out  CH  bit c = LUT[c][index_c].
- sweep_start  in  1  single-cycle request to sweep a channel.
- sweep_ch  in  clog2(CH)  channel to sweep; sampled with sweep_start.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the signature is final.
- sweep_sig  out  SIG_W  signature; holds its value until the next accepted sweep.

Behaviour:
- Reset: all LUTs 0, out_valid 0, out_data 0, sweep_busy 0, sweep_done 0, sweep_sig 0, FSM in IDLE. Reset is asynchronous and may assert at any cycle, including mid-sweep; it aborts everything.
- cfg_ready = (state == IDLE), combinational from state only.
- Config write: cfg_valid && cfg_ready at a rising edge writes cfg_lut into LUT[cfg_ch]. cfg_ch >= CH is dropped silently, but the handshake still completes.
- Evaluation:
  - Latency 1 cycle: out_valid(t+1) = in_valid(t); out_data(t+1) = LUT values indexed by in_data(t).
  - out_data updates only when in_valid = 1, otherwise it holds.
  - Evaluation is allowed in every state.
  - A config write and an evaluation in the same cycle: the evaluation uses the LUT contents from before the write.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start. At that edge: latch sweep_ch, set cnt = 0, set sweep_sig = 0, set sweep_busy = 1. sweep_ch >= CH is treated as channel 0.
  - SWEEP: each cycle, sweep_sig <= rotl(sweep_sig, 1) XOR {0..., LUT[ch][cnt]}, then cnt <= cnt + 1. When cnt == 2^NIN-1, the last bit is processed and the FSM goes to DONE. A sweep takes exactly 2^NIN cycles; cnt is NIN+1 bits wide so it never wraps early.
  - DONE: one cycle with sweep_done = 1 and sweep_busy = 0, then return to IDLE.
  - sweep_start in SWEEP or DONE is ignored; it is not queued.
- sweep_start and cfg_valid in the same IDLE cycle: both are accepted. The write lands first and the sweep reads the updated LUT.
- Config is frozen during SWEEP and DONE (cfg_ready = 0), so the signature always reflects a stable table.

Test Plan:
- Reset/defaults: hold rst_n low 3 cycles, release -> every output 0 and cfg_ready = 1. Evaluate any input -> out_data = 4'b0000 one cycle later.
- Config + evaluate (NIN=3, CH=4): load ch0 = 8'hE8 (majority), then drive ch0 index 3'b011 -> out_data[0] = 1; drive index 3'b100 -> out_data[0] = 0. out_valid follows in_valid with 1-cycle latency.
- Sweep signature: load ch2 = 8'hE8, pulse sweep_start with sweep_ch = 2 -> sweep_busy high for exactly 8 cycles, sweep_done pulses once, sweep_sig = 16'h0017.
- Busy handling: during the sweep, assert cfg_valid (cfg_ready must read 0, LUT unchanged) and sweep_start (ignored); also evaluate -> results stay correct throughout.
- Simultaneous events: in the same IDLE cycle, load ch1 = 8'hFF and pulse sweep_start on ch1 -> sweep_sig = 16'h00FF.
- Reset mid-sweep: assert rst_n low at sweep cycle 4 -> next cycle sweep_busy = 0, sweep_sig = 0, ch0 LUT reads 0, and no sweep_done pulse.
